// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: column strobe, 2-flop row synchronizer,
// press/release debounce. Define KEYPAD_STROBE_EN to add the one-cycle key_strobe output.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_pressed,
    output logic [3:0] key_code,
`ifdef KEYPAD_STROBE_EN
    output logic [2:0] is_sign_key,
    output logic       key_strobe
`else
    output logic [2:0] is_sign_key
`endif
);

    localparam int MAX_CNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        r_state, w_state_nx;
    logic [3:0]    r_sync1, r_sync2;
    logic [CW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic [1:0]    r_col_idx, w_col_nx;
    logic [1:0]    r_row, w_row_nx, w_low_row;
    logic          r_key_pressed;
    logic [3:0]    r_key_code, w_code;
    logic [2:0]    r_sign, w_sign;
    logic          w_any_low, w_row_lvl, w_accept, w_release;

    assign col_out     = ~(4'b0001 << r_col_idx);
    assign key_pressed = r_key_pressed;
    assign key_code    = r_key_code;
    assign is_sign_key = r_sign;

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
    assign w_any_low = ~&r_sync2;
    assign w_row_lvl = r_sync2[r_row];

    // Lowest-index low row wins when several rows are pulled down together.
    always_comb begin
        w_low_row = 2'd3;
        if (!r_sync2[2]) w_low_row = 2'd2;
        if (!r_sync2[1]) w_low_row = 2'd1;
        if (!r_sync2[0]) w_low_row = 2'd0;
    end

    always_comb begin
        w_code = '0;
        w_sign = '0;
        case ({r_row, r_col_idx})
            4'd0:  w_code = 4'h1;
            4'd1:  w_code = 4'h2;
            4'd2:  w_code = 4'h3;
            4'd3:  begin w_code = 4'hA; w_sign = 3'b001; end
            4'd4:  w_code = 4'h4;
            4'd5:  w_code = 4'h5;
            4'd6:  w_code = 4'h6;
            4'd7:  begin w_code = 4'hB; w_sign = 3'b010; end
            4'd8:  w_code = 4'h7;
            4'd9:  w_code = 4'h8;
            4'd10: w_code = 4'h9;
            4'd11: begin w_code = 4'hC; w_sign = 3'b011; end
            4'd12: begin w_code = 4'hE; w_sign = 3'b101; end
            4'd13: w_code = 4'h0;
            4'd14: begin w_code = 4'hF; w_sign = 3'b111; end
            default: begin w_code = 4'hD; w_sign = 3'b100; end
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_col_nx   = r_col_idx;
        w_row_nx   = r_row;
        w_accept   = 1'b0;
        w_release  = 1'b0;
        case (r_state)
            SCAN: begin
                if (r_cnt >= SCAN_LAST) begin
                    w_cnt_nx = '0;
                    if (w_any_low) begin
                        w_row_nx   = w_low_row;
                        w_state_nx = DEBOUNCE;
                    end else begin
                        w_col_nx = r_col_idx + 2'd1;
                    end
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            DEBOUNCE: begin
                if (!w_row_lvl) begin
                    if (r_cnt >= DB_LAST) begin
                        w_cnt_nx   = '0;
                        w_accept   = 1'b1;
                        w_state_nx = HELD;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end else begin
                    w_cnt_nx   = '0;
                    w_col_nx   = r_col_idx + 2'd1;
                    w_state_nx = SCAN;
                end
            end
            HELD: begin
                if (w_row_lvl) begin
                    w_cnt_nx   = '0;
                    w_state_nx = RELEASE;
                end
            end
            RELEASE: begin
                if (w_row_lvl) begin
                    if (r_cnt >= DB_LAST) begin
                        w_cnt_nx   = '0;
                        w_release  = 1'b1;
                        w_col_nx   = r_col_idx + 2'd1;
                        w_state_nx = SCAN;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end else begin
                    w_cnt_nx   = '0;
                    w_state_nx = HELD;
                end
            end
            default: w_state_nx = SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1       <= '1;
            r_sync2       <= '1;
            r_state       <= SCAN;
            r_cnt         <= '0;
            r_col_idx     <= '0;
            r_row         <= '0;
            r_key_pressed <= 1'b0;
            r_key_code    <= '0;
            r_sign        <= '0;
        end else begin
            r_sync1   <= row_in;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_col_idx <= w_col_nx;
            r_row     <= w_row_nx;
            if (w_accept) begin
                r_key_pressed <= 1'b1;
                r_key_code    <= w_code;
                r_sign        <= w_sign;
            end else if (w_release) begin
                r_key_pressed <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_STROBE_EN
    logic r_strobe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_strobe <= 1'b0;
        else     r_strobe <= w_accept;
    end

    assign key_strobe = r_strobe;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad stimulus, thread-style reference model,
// per-cycle output compare plus directed literal checks.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_in = 4'hF;
    logic [3:0] col_out;
    logic       key_pressed;
    logic [3:0] key_code;
    logic [2:0] is_sign_key;
`ifdef KEYPAD_STROBE_EN
    logic       key_strobe;
`endif

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_pressed (key_pressed),
        .key_code    (key_code),
`ifdef KEYPAD_STROBE_EN
        .is_sign_key (is_sign_key),
        .key_strobe  (key_strobe)
`else
        .is_sign_key (is_sign_key)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rises  = 0;
    int strobes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- physical keypad ----------------
    bit         keys_down [16];
    bit         use_force = 1'b0;
    logic [3:0] force_rows = 4'hF;
    logic [3:0] kp_rows;

    initial forever begin
        @(negedge clk);
        kp_rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_down[r*4+c] && !col_out[c]) kp_rows[r] = 1'b0;
        row_in = use_force ? force_rows : kp_rows;
    end

    // ---------------- reference model ----------------
    string      keymap = "123A456B789C*0#D";
    logic [3:0] s1 = 4'hF, s2 = 4'hF, seen = 4'hF;
    bit         m_rst_hit;
    int         m_col = 0;
    bit         m_pressed = 1'b0;
    logic [3:0] m_code = 4'h0;
    logic [2:0] m_sign = 3'd0;
    bit         m_strobe = 1'b0;

    function automatic logic [3:0] key_value(input byte ch);
        if (ch == "*") return 4'hE;
        if (ch == "#") return 4'hF;
        if (ch >= "A") return 4'(ch - "A" + 8'd10);
        return 4'(ch - "0");
    endfunction

    function automatic logic [2:0] key_class(input byte ch);
        case (ch)
            "A": return 3'd1;
            "B": return 3'd2;
            "C": return 3'd3;
            "D": return 3'd4;
            "*": return 3'd5;
            "#": return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic int lowest_low(input logic [3:0] rows);
        for (int r = 0; r < 4; r++) if (!rows[r]) return r;
        return 0;
    endfunction

    // One clock edge: decisions use the synchronized rows as they stood before the edge.
    task automatic edge_step();
        @(posedge clk);
        seen      = s2;
        s2        = s1;
        s1        = row_in;
        m_strobe  = 1'b0;
        m_rst_hit = rst;
        if (rst) begin
            s1 = 4'hF; s2 = 4'hF;
            m_col = 0; m_pressed = 1'b0; m_code = 4'h0; m_sign = 3'd0;
        end
    endtask

    initial begin : ref_model
        int row, n;
        bit done;
        forever begin
            for (int k = 0; k < SD; k++) begin
                edge_step();
                if (m_rst_hit) break;
            end
            if (m_rst_hit) continue;
            if (seen == 4'hF) begin m_col = (m_col + 1) % 4; continue; end
            row = lowest_low(seen);
            n = 0; done = 1'b0;
            while (!done) begin
                edge_step();
                if (m_rst_hit || seen[row]) break;
                n++;
                if (n == DB) done = 1'b1;
            end
            if (m_rst_hit) continue;
            if (!done) begin m_col = (m_col + 1) % 4; continue; end
            m_pressed = 1'b1;
            m_strobe  = 1'b1;
            m_code    = key_value(keymap[row*4+m_col]);
            m_sign    = key_class(keymap[row*4+m_col]);
            done = 1'b0;
            while (!done) begin
                edge_step();
                if (m_rst_hit) break;
                if (seen[row]) begin
                    n = 0;
                    forever begin
                        edge_step();
                        if (m_rst_hit || !seen[row]) break;
                        n++;
                        if (n == DB) begin done = 1'b1; break; end
                    end
                    if (m_rst_hit) break;
                end
            end
            if (m_rst_hit) continue;
            m_pressed = 1'b0;
            m_col = (m_col + 1) % 4;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        logic [3:0] exp_col;
        bit prev_kp;
        prev_kp = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            exp_col = ~(4'b0001 << m_col);
            check("col_out", int'(col_out), int'(exp_col));
            check("key_pressed", int'(key_pressed), int'(m_pressed));
            check("key_code", int'(key_code), int'(m_code));
            check("is_sign_key", int'(is_sign_key), int'(m_sign));
`ifdef KEYPAD_STROBE_EN
            check("key_strobe", int'(key_strobe), int'(m_strobe));
            if (key_strobe) strobes++;
`endif
            if (key_pressed && !prev_kp) rises++;
            prev_kp = key_pressed;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_col_start(input logic [3:0] want, input string tag);
        logic [3:0] prev;
        bit ok;
        ok = 1'b0;
        prev = col_out;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (col_out == want && prev != want) begin ok = 1'b1; break; end
            prev = col_out;
        end
        check(tag, int'(ok), 1);
    endtask

    task automatic wait_kp(input bit val, input int bound, input string tag, output int n);
        n = 0;
        while (key_pressed != val && n < bound) begin tick(); n++; end
        check(tag, int'(key_pressed), int'(val));
    endtask

    task automatic release_all();
        foreach (keys_down[i]) keys_down[i] = 1'b0;
    endtask

    initial begin : stim
        int n, r0, mode, k;
        release_all();
        repeat (3) tick();
        check("reset col_out", int'(col_out), 4'hE);
        check("reset key_pressed", int'(key_pressed), 0);
        check("reset key_code", int'(key_code), 0);
        check("reset is_sign_key", int'(is_sign_key), 0);
        rst = 1'b0;

        // key '8' at (r2,c1), held 40 cycles
        wait_col_start(4'b1101, "col1 start");
        keys_down[9] = 1'b1;
        repeat (40) tick();
        check("k8 pressed", int'(key_pressed), 1);
        check("k8 code", int'(key_code), 4'h8);
        check("k8 class", int'(is_sign_key), 0);
        keys_down[9] = 1'b0;
        wait_kp(1'b0, 200, "k8 release", n);
        check("k8 release delay >= DB", int'(n >= DB), 1);

        // 'A' then '#'
        keys_down[3] = 1'b1;
        repeat (60) tick();
        check("kA code", int'(key_code), 4'hA);
        check("kA class", int'(is_sign_key), 3'b001);
        check("model kA code", int'(m_code), 4'hA);
        keys_down[3] = 1'b0;
        wait_kp(1'b0, 200, "kA release", n);
        keys_down[14] = 1'b1;
        repeat (60) tick();
        check("k# code", int'(key_code), 4'hF);
        check("k# class", int'(is_sign_key), 3'b111);
        check("model k# class", int'(m_sign), 3'b111);
        keys_down[14] = 1'b0;
        wait_kp(1'b0, 200, "k# release", n);
        check("k# code held", int'(key_code), 4'hF);

        // row1 bounce while col0 is driven
        r0 = rises;
        force_rows = 4'hF;
        use_force = 1'b1;
        wait_col_start(4'b1110, "col0 start");
        force_rows = 4'b1101;
        repeat (5) tick();
        force_rows = 4'hF;
        repeat (2) tick();
        force_rows = 4'b1101;
        tick();
        check("bounce resumes col1", int'(col_out), 4'b1101);
        repeat (4) tick();
        force_rows = 4'hF;
        repeat (20) tick();
        use_force = 1'b0;
        check("bounce no press", int'(key_pressed), 0);
        check("bounce no rise", rises - r0, 0);

        // rows 1 and 3 on col2 together
        wait_col_start(4'b1011, "col2 start");
        r0 = rises;
        keys_down[6] = 1'b1;
        keys_down[14] = 1'b1;
        repeat (30) tick();
        check("multi code", int'(key_code), 4'h6);
        release_all();
        wait_kp(1'b0, 200, "multi release", n);
        check("multi one press", rises - r0, 1);

        // reset during HELD, key still down afterwards
        keys_down[0] = 1'b1;
        wait_kp(1'b1, 100, "k1 press", n);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("rst held col_out", int'(col_out), 4'hE);
        check("rst held key_pressed", int'(key_pressed), 0);
        check("rst held key_code", int'(key_code), 0);
        repeat (2) tick();
        rst = 1'b0;
        r0 = rises;
        repeat (60) tick();
        check("re-accept pressed", int'(key_pressed), 1);
        check("re-accept code", int'(key_code), 4'h1);
        check("re-accept once", rises - r0, 1);
        keys_down[0] = 1'b0;
        wait_kp(1'b0, 200, "k1 release", n);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 9);
            k    = $urandom_range(0, 15);
            if (mode <= 6) begin
                keys_down[k] = 1'b1;
                repeat ($urandom_range(1, 40)) tick();
                keys_down[k] = 1'b0;
            end else if (mode == 7) begin
                keys_down[k] = 1'b1;
                keys_down[$urandom_range(0, 15)] = 1'b1;
                repeat ($urandom_range(1, 40)) tick();
                release_all();
            end else if (mode == 8) begin
                use_force = 1'b1;
                repeat ($urandom_range(2, 6)) begin
                    force_rows = 4'($urandom_range(0, 15));
                    repeat ($urandom_range(1, 6)) tick();
                end
                force_rows = 4'hF;
                use_force = 1'b0;
            end else begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 30)) tick();
        end
        release_all();
        repeat (60) tick();
        check("final idle", int'(key_pressed), 0);
`ifdef KEYPAD_STROBE_EN
        check("strobe count", strobes, rises);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
